// File: rtl/vend_pkg.sv
// Shared state encodings and credit width for the vending controller.
package vend_pkg;

    localparam int CRED_W = 5;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        ACCUM  = 5'b00010,
        VEND   = 5'b00100,
        CHANGE = 5'b01000,
        REFUND = 5'b10000
    } state_t;

endpackage

// File: rtl/vend_ctrl_if.sv
// Customer-side coin/cancel inputs and dispense/status outputs of the vending controller.
// master: coin mechanism / bench side; slave: controller side.
interface vend_ctrl_if #(
    parameter int CNT_W = 8
);
    import vend_pkg::*;

    logic              pi_half;
    logic              pi_one;
    logic              pi_cancel;
    logic              po_cola;
    logic              po_change;
    logic              po_busy;
    logic [CRED_W-1:0] po_credit;
    logic [CNT_W-1:0]  po_sold;

    modport master (
        output pi_half, pi_one, pi_cancel,
        input  po_cola, po_change, po_busy, po_credit, po_sold
    );

    modport slave (
        input  pi_half, pi_one, pi_cancel,
        output po_cola, po_change, po_busy, po_credit, po_sold
    );

endinterface

// File: rtl/vend_change_out.sv
// Credit register with load/decrement and the one-per-half-unit change pulse.
// Latency: credit and pulse update on the edge after ld/dec; backpressure: none.
module vend_change_out
    import vend_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [CRED_W-1:0] ld_val,
    input  logic              dec,
    output logic [CRED_W-1:0] credit,
    output logic              change
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
            change <= 1'b0;
        end else begin
            change <= dec;
            if (ld) begin
                credit <= ld_val;
            end else if (dec) begin
                credit <= credit - CRED_W'(1);
            end
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Coin-accumulating vending controller: sells at PRICE half-units, returns change, refunds on cancel.
// Latency: po_cola one edge after price reached, then one change pulse per edge; backpressure: inputs ignored while po_busy.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE = 5,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    vend_ctrl_if.slave bus
);

    localparam logic [CRED_W-1:0] PRICE_C = CRED_W'(PRICE);
    localparam logic [CRED_W-1:0] MAX_C   = CRED_W'(PRICE + 1);

    state_t            state;
    logic              cola;
    logic              busy;
    logic [CNT_W-1:0]  sold;
    logic [CRED_W-1:0] credit;
    logic              change;
    logic [CRED_W:0]   sum;
    logic [CRED_W-1:0] add_val;
    logic [CRED_W-1:0] rem;
    logic              accepting;
    logic              ld;
    logic [CRED_W-1:0] ld_val;
    logic              dec;

    // Credit is capped at PRICE+1 so simultaneous coins can never overflow the register.
    always_comb begin
        sum = {1'b0, credit}
            + {{CRED_W{1'b0}}, bus.pi_half}
            + {{(CRED_W-1){1'b0}}, bus.pi_one, 1'b0};
        add_val   = (sum > {1'b0, MAX_C}) ? MAX_C : sum[CRED_W-1:0];
        rem       = credit - PRICE_C;
        accepting = (state == IDLE) || (state == ACCUM);
        ld        = accepting || (state == VEND);
        ld_val    = (state == VEND) ? rem : add_val;
        dec       = (state == CHANGE) || (state == REFUND);
    end

    vend_change_out u_change_out (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (ld),
        .ld_val (ld_val),
        .dec    (dec),
        .credit (credit),
        .change (change)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cola  <= 1'b0;
            busy  <= 1'b0;
            sold  <= '0;
        end else begin
            cola <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    if (bus.pi_cancel && (add_val != '0)) begin
                        state <= REFUND;
                        busy  <= 1'b1;
                    end else if (add_val >= PRICE_C) begin
                        state <= VEND;
                        busy  <= 1'b1;
                    end else if (add_val != '0) begin
                        state <= ACCUM;
                        busy  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                VEND: begin
                    cola <= 1'b1;
                    sold <= sold + CNT_W'(1);
                    if (rem != '0) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CHANGE, REFUND: begin
                    // This edge pays out the last half-unit when credit is 1.
                    if (credit == CRED_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.po_cola   = cola;
    assign bus.po_change = change;
    assign bus.po_busy   = busy;
    assign bus.po_credit = credit;
    assign bus.po_sold   = sold;

endmodule
